lpddr2_port_arbiter: RTL and testbench

- Shares one LPDDR2 multiport Avalon-MM command port between two requesters:
  - m0: HDMI-RX capture writer.
  - m1: video-generator frame reader.
- Sits between the requesters and the fpga_lpddr2 avl_* port.
- Arbitrates commands and locks the port for the whole of a write burst.
- Tags outstanding reads so that returning read data is steered to the requester that issued them.

---
 rtl/lpddr2_port_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_lpddr2_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpddr2_port_arbiter.sv
// Two-requester arbiter for one LPDDR2 Avalon-MM command port, with write-burst lock and read tag steering.
// Define ARB_READ_PRIORITY_EN to give m1 fixed priority with a MAX_GRANT starvation guard for m0.
module lpddr2_port_arbiter #(
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 32,
  parameter int BURST_W   = 3,
  parameter int TAG_DEPTH = 8,
  parameter int MAX_GRANT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [ADDR_W-1:0]  m0_address,
  input  logic [DATA_W-1:0]  m0_writedata,
  input  logic [BURST_W-1:0] m0_burstcount,
  output logic               m0_waitrequest_n,
  output logic               m0_readdatavalid,
  output logic [DATA_W-1:0]  m0_readdata,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [ADDR_W-1:0]  m1_address,
  input  logic [DATA_W-1:0]  m1_writedata,
  input  logic [BURST_W-1:0] m1_burstcount,
  output logic               m1_waitrequest_n,
  output logic               m1_readdatavalid,
  output logic [DATA_W-1:0]  m1_readdata,
  input  logic               avl_ready,
  output logic               avl_burstbegin,
  output logic [ADDR_W-1:0]  avl_addr,
  output logic [DATA_W-1:0]  avl_wdata,
  output logic [BURST_W-1:0] avl_size,
  output logic               avl_read_req,
  output logic               avl_write_req,
  input  logic               avl_rdata_valid,
  input  logic [DATA_W-1:0]  avl_rdata,
  output logic               err_orphan_rdata,
  output logic               grant_id
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic               grant_vld_q, grant_vld_d, grant_id_q, grant_id_d;
  logic               lock_q, lock_d, bb_sent_q, bb_sent_d, err_q, err_d;
  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d, head_cnt_q, head_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   tag_cnt_q, tag_cnt_d;
  logic               tag_id_q  [TAG_DEPTH];
  logic [BURST_W-1:0] tag_len_q [TAG_DEPTH];
`ifdef ARB_READ_PRIORITY_EN
  localparam int RUN_W = $clog2(MAX_GRANT + 1);
  logic [RUN_W-1:0]   run_q, run_d;
`else
  logic               favour_q, favour_d;
  logic               unused_max_grant;
  // MAX_GRANT has no role under round-robin arbitration.
  assign unused_max_grant = ^MAX_GRANT;
`endif

  logic               g_read, g_write, pend0, pend1, tag_full, tag_empty;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_wdata;
  logic [BURST_W-1:0] g_bc, eff_bc;
  logic               accept, wr_acc, rd_acc, last_beat, cmd_done, rd_hit, pop;

  assign g_read    = grant_id_q ? m1_read       : m0_read;
  assign g_write   = grant_id_q ? m1_write      : m0_write;
  assign g_addr    = grant_id_q ? m1_address    : m0_address;
  assign g_wdata   = grant_id_q ? m1_writedata  : m0_writedata;
  assign g_bc      = grant_id_q ? m1_burstcount : m0_burstcount;
  assign eff_bc    = (g_bc == '0) ? BURST_W'(1) : g_bc;
  assign pend0     = m0_read | m0_write;
  assign pend1     = m1_read | m1_write;
  assign tag_full  = (tag_cnt_q == CNT_W'(TAG_DEPTH));
  assign tag_empty = (tag_cnt_q == '0);

  assign accept    = avl_ready & (avl_read_req | avl_write_req);
  assign wr_acc    = accept & avl_write_req;
  assign rd_acc    = accept & avl_read_req;
  assign last_beat = lock_q ? (beat_cnt_q == BURST_W'(1)) : (eff_bc == BURST_W'(1));
  assign cmd_done  = rd_acc | (wr_acc & last_beat);
  assign rd_hit    = avl_rdata_valid & ~tag_empty;
  assign pop       = rd_hit & (head_cnt_q == tag_len_q[rd_ptr_q] - BURST_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_vld_q <= 1'b0;
      grant_id_q  <= 1'b0;
      lock_q      <= 1'b0;
      bb_sent_q   <= 1'b0;
      err_q       <= 1'b0;
      beat_cnt_q  <= '0;
      head_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tag_cnt_q   <= '0;
`ifdef ARB_READ_PRIORITY_EN
      run_q       <= '0;
`else
      favour_q    <= 1'b1;
`endif
    end else begin
      grant_vld_q <= grant_vld_d;
      grant_id_q  <= grant_id_d;
      lock_q      <= lock_d;
      bb_sent_q   <= bb_sent_d;
      err_q       <= err_d;
      beat_cnt_q  <= beat_cnt_d;
      head_cnt_q  <= head_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tag_cnt_q   <= tag_cnt_d;
`ifdef ARB_READ_PRIORITY_EN
      run_q       <= run_d;
`else
      favour_q    <= favour_d;
`endif
    end
  end

  // Tag payload storage needs no reset; occupancy is tracked by tag_cnt_q.
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      tag_id_q[wr_ptr_q]  <= grant_id_q;
      tag_len_q[wr_ptr_q] <= eff_bc;
    end
  end

  always_comb begin
    grant_vld_d = grant_vld_q;
    grant_id_d  = grant_id_q;
    lock_d      = lock_q;
    beat_cnt_d  = beat_cnt_q;
    bb_sent_d   = cmd_done ? 1'b0 : (bb_sent_q | avl_burstbegin);
    err_d       = err_q | (avl_rdata_valid & tag_empty);
    head_cnt_d  = head_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tag_cnt_d   = tag_cnt_q;
`ifdef ARB_READ_PRIORITY_EN
    run_d       = run_q;
`else
    favour_d    = favour_q;
`endif

    if (wr_acc) begin
      if (lock_q) begin
        beat_cnt_d = beat_cnt_q - BURST_W'(1);
        lock_d     = ~last_beat;
      end else if (!last_beat) begin
        lock_d     = 1'b1;
        beat_cnt_d = eff_bc - BURST_W'(1);
      end
    end

    if (!grant_vld_q) begin
      if (pend0 | pend1) begin
        grant_vld_d = 1'b1;
`ifdef ARB_READ_PRIORITY_EN
        grant_id_d  = pend1;
`else
        grant_id_d  = (pend0 & pend1) ? favour_q : pend1;
        favour_d    = ~grant_id_d;
`endif
      end
    end else if (cmd_done) begin
`ifdef ARB_READ_PRIORITY_EN
      // m1 keeps the port until it has completed MAX_GRANT commands while m0 waits.
      if (grant_id_q) begin
        if (pend0) begin
          if (run_q == RUN_W'(MAX_GRANT - 1)) begin
            grant_id_d = 1'b0;
            run_d      = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end
      end else begin
        run_d = '0;
        if (pend1) grant_id_d = 1'b1;
      end
`else
      if (grant_id_q ? pend0 : pend1) grant_id_d = ~grant_id_q;
      favour_d = ~grant_id_d;
`endif
    end else if (!lock_q && !g_read && !g_write) begin
      grant_vld_d = 1'b0;
      bb_sent_d   = 1'b0;
    end

    if (rd_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_hit) head_cnt_d = pop ? '0 : head_cnt_q + BURST_W'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (rd_acc && !pop)      tag_cnt_d = tag_cnt_q + CNT_W'(1);
    else if (!rd_acc && pop) tag_cnt_d = tag_cnt_q - CNT_W'(1);
  end

  always_comb begin
    avl_write_req    = grant_vld_q & g_write;
    avl_read_req     = grant_vld_q & g_read & ~g_write & ~tag_full;
    avl_burstbegin   = (avl_write_req | avl_read_req) & ~bb_sent_q;
    avl_addr         = grant_vld_q ? g_addr  : '0;
    avl_wdata        = grant_vld_q ? g_wdata : '0;
    avl_size         = grant_vld_q ? g_bc    : '0;
    m0_waitrequest_n = avl_ready & ~grant_id_q & (avl_write_req | avl_read_req);
    m1_waitrequest_n = avl_ready &  grant_id_q & (avl_write_req | avl_read_req);
    m0_readdatavalid = rd_hit & ~tag_id_q[rd_ptr_q];
    m1_readdatavalid = rd_hit &  tag_id_q[rd_ptr_q];
    m0_readdata      = avl_rdata;
    m1_readdata      = avl_rdata;
  end

  assign err_orphan_rdata = err_q;
  assign grant_id         = grant_id_q;

endmodule

// File: tb/tb_lpddr2_port_arbiter.sv
// Self-checking bench for lpddr2_port_arbiter: vector table for the write-burst trace plus scoreboarded sequences.
module tb_lpddr2_port_arbiter;
  localparam int AW = 27;
  localparam int DW = 32;
  localparam int BW = 3;
  localparam int TD = 8;
  localparam int MG = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [AW-1:0] m0_address, m1_address;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic [BW-1:0] m0_burstcount, m1_burstcount;
  logic          m0_waitrequest_n, m0_readdatavalid, m1_waitrequest_n, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          avl_ready, avl_burstbegin, avl_read_req, avl_write_req, avl_rdata_valid;
  logic [AW-1:0] avl_addr;
  logic [DW-1:0] avl_wdata, avl_rdata;
  logic [BW-1:0] avl_size;
  logic          err_orphan_rdata, grant_id;

  always #5 clk = ~clk;

  lpddr2_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .TAG_DEPTH(TD), .MAX_GRANT(MG)) dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address), .m0_writedata(m0_writedata),
    .m0_burstcount(m0_burstcount), .m0_waitrequest_n(m0_waitrequest_n),
    .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address), .m1_writedata(m1_writedata),
    .m1_burstcount(m1_burstcount), .m1_waitrequest_n(m1_waitrequest_n),
    .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
    .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin), .avl_addr(avl_addr),
    .avl_wdata(avl_wdata), .avl_size(avl_size), .avl_read_req(avl_read_req),
    .avl_write_req(avl_write_req), .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
    .err_orphan_rdata(err_orphan_rdata), .grant_id(grant_id)
  );

  typedef struct { bit id; logic [DW-1:0] data; } rd_exp_t;
  typedef struct { bit m0_wr; bit m1_rd; bit m0_wn; bit m1_wn; bit wr; bit rd; bit bb; bit gid; } vec_t;

  rd_exp_t exp_rd[$];
  bit      exp_cmd[$];
  bit      mon_cmd_en = 1'b0;
  vec_t    vecs[7];
  int      errors = 0;
  int      checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    rd_exp_t e;
    bit      b;
    if (m0_readdatavalid || m1_readdatavalid) begin
      chk("rdv_onehot", 32'(m0_readdatavalid & m1_readdatavalid), 0);
      if (exp_rd.size() == 0) begin
        chk("rdv_unexpected", 32'(1), 0);
      end else begin
        e = exp_rd.pop_front();
        chk("rdv_id", 32'(m1_readdatavalid), 32'(e.id));
        chk("rdv_data", m1_readdatavalid ? m1_readdata : m0_readdata, e.data);
        $display("read beat -> m%0d data=0x%0h", m1_readdatavalid, avl_rdata);
      end
    end
    if (mon_cmd_en) begin
      if (m1_waitrequest_n && (m1_read || m1_write) && exp_cmd.size() > 0) begin
        b = exp_cmd.pop_front();
        chk("cmd_order", 32'(1), 32'(b));
        $display("accepted command from m1");
      end
      if (m0_waitrequest_n && (m0_read || m0_write) && exp_cmd.size() > 0) begin
        b = exp_cmd.pop_front();
        chk("cmd_order", 32'(0), 32'(b));
        $display("accepted command from m0");
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic clear_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_burstcount = 1; m1_burstcount = 1;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    avl_rdata_valid = 0; avl_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    repeat (3) cyc();
    reset = 0;
  endtask

  task automatic issue(input bit id, input bit rd, input logic [BW-1:0] bc);
    bit done = 0;
    if (id) begin
      m1_read = rd; m1_write = !rd; m1_burstcount = bc; m1_address = 27'h100;
    end else begin
      m0_read = rd; m0_write = !rd; m0_burstcount = bc; m0_address = 27'h200;
    end
    for (int t = 0; t < 40 && !done; t++) begin
      settle();
      if (id ? m1_waitrequest_n : m0_waitrequest_n) done = 1;
      tick();
    end
    if (id) begin m1_read = 0; m1_write = 0; end
    else    begin m0_read = 0; m0_write = 0; end
    chk("issue_accept", 32'(done), 1);
    $display("issued %s from m%0d bc=%0d", rd ? "read" : "write", id, bc);
  endtask

  task automatic rdata_beat(input bit id, input logic [DW-1:0] d);
    exp_rd.push_back('{id: id, data: d});
    avl_rdata_valid = 1;
    avl_rdata = d;
    cyc();
    avl_rdata_valid = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          m0_wr m1_rd m0_wn m1_wn wr rd bb gid
    vecs[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 1, 0, 1, 0, 1, 0};
    vecs[2] = '{1, 1, 1, 0, 1, 0, 0, 0};
    vecs[3] = '{1, 1, 1, 0, 1, 0, 0, 0};
    vecs[4] = '{1, 1, 1, 0, 1, 0, 0, 0};
    vecs[5] = '{0, 1, 0, 1, 0, 1, 1, 1};
    vecs[6] = '{0, 0, 0, 0, 0, 0, 0, 1};

    avl_ready = 1;
    do_reset();

    // Idle state after reset
    settle();
    chk("rst_read_req", 32'(avl_read_req), 0);
    chk("rst_write_req", 32'(avl_write_req), 0);
    chk("rst_burstbegin", 32'(avl_burstbegin), 0);
    chk("rst_addr", 32'(avl_addr), 0);
    chk("rst_m0_wn", 32'(m0_waitrequest_n), 0);
    chk("rst_m1_wn", 32'(m1_waitrequest_n), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_err", 32'(err_orphan_rdata), 0);
    tick();
    $display("reset state checked");

    // Write burst of 4 from m0, m1 read raised mid-burst
    m0_burstcount = 4;
    m1_burstcount = 1;
    m0_address = 27'h0ABC;
    for (int i = 0; i < 7; i++) begin
      m0_write = vecs[i].m0_wr;
      m1_read = vecs[i].m1_rd;
      m0_writedata = 32'hA000_0000 + 32'(i);
      settle();
      chk("bst_m0_wn", 32'(m0_waitrequest_n), 32'(vecs[i].m0_wn));
      chk("bst_m1_wn", 32'(m1_waitrequest_n), 32'(vecs[i].m1_wn));
      chk("bst_write_req", 32'(avl_write_req), 32'(vecs[i].wr));
      chk("bst_read_req", 32'(avl_read_req), 32'(vecs[i].rd));
      chk("bst_burstbegin", 32'(avl_burstbegin), 32'(vecs[i].bb));
      chk("bst_grant_id", 32'(grant_id), 32'(vecs[i].gid));
      if (vecs[i].wr) begin
        chk("bst_wdata", avl_wdata, 32'hA000_0000 + 32'(i));
        chk("bst_size", 32'(avl_size), 4);
        chk("bst_addr", 32'(avl_addr), 32'h0ABC);
      end
      $display("burst row %0d: wr=%0b rd=%0b bb=%0b gid=%0b", i, avl_write_req, avl_read_req, avl_burstbegin, grant_id);
      tick();
    end
    clear_inputs();
    rdata_beat(1, 32'hBEEF_0001);
    cyc();
    chk("bst_rd_drained", 32'(exp_rd.size()), 0);

    // Continuous single-beat commands from both requesters
    do_reset();
    for (int i = 0; i < 18; i++) begin
`ifdef ARB_READ_PRIORITY_EN
      exp_cmd.push_back((i % (MG + 1)) != MG);
`else
      exp_cmd.push_back((i % 2) == 0);
`endif
    end
    mon_cmd_en = 1;
    m0_write = 1; m0_burstcount = 1;
    m1_write = 1; m1_burstcount = 1;
    for (int t = 0; t < 80 && exp_cmd.size() > 0; t++) cyc();
    chk("alt_all_accepted", 32'(exp_cmd.size()), 0);
    mon_cmd_en = 0;
    clear_inputs();
    repeat (2) cyc();

    // Read tag steering: m0 bc2, m1 bc1, m0 bc1
    do_reset();
    issue(0, 1, 2);
    issue(1, 1, 1);
    issue(0, 1, 1);
    for (int i = 0; i < 4; i++) rdata_beat((i == 2), 32'hD0D0_0000 + 32'(i));
    repeat (2) cyc();
    chk("tag_rd_drained", 32'(exp_rd.size()), 0);

    // Tag FIFO full: 9th read is held until one burst returns
    do_reset();
    for (int i = 0; i < TD; i++) issue(1, 1, 1);
    m1_read = 1; m1_burstcount = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("full_read_req", 32'(avl_read_req), 0);
      chk("full_m1_wn", 32'(m1_waitrequest_n), 0);
      tick();
    end
    settle();
    chk("full_grant_kept", 32'(grant_id), 1);
    tick();
    exp_rd.push_back('{id: 1'b1, data: 32'hF00D_0000});
    avl_rdata_valid = 1;
    avl_rdata = 32'hF00D_0000;
    settle();
    chk("full_pop_cycle_wn", 32'(m1_waitrequest_n), 0);
    tick();
    avl_rdata_valid = 0;
    settle();
    chk("full_after_pop_read_req", 32'(avl_read_req), 1);
    chk("full_after_pop_wn", 32'(m1_waitrequest_n), 1);
    chk("full_after_pop_bb", 32'(avl_burstbegin), 1);
    tick();
    m1_read = 0;
    cyc();
    chk("full_rd_drained", 32'(exp_rd.size()), 0);

    // Orphan read data after a reset that flushed an outstanding read
    do_reset();
    issue(0, 1, 2);
    do_reset();
    settle();
    chk("orph_err_clear", 32'(err_orphan_rdata), 0);
    tick();
    avl_rdata_valid = 1;
    avl_rdata = 32'h0BAD_0BAD;
    settle();
    chk("orph_m0_rdv", 32'(m0_readdatavalid), 0);
    chk("orph_m1_rdv", 32'(m1_readdatavalid), 0);
    tick();
    avl_rdata_valid = 0;
    settle();
    chk("orph_err_set", 32'(err_orphan_rdata), 1);
    tick();
    repeat (4) cyc();
    settle();
    chk("orph_err_sticky", 32'(err_orphan_rdata), 1);
    tick();
    $display("orphan data flagged");
    do_reset();
    settle();
    chk("orph_err_reset", 32'(err_orphan_rdata), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
